// File: rtl/fourway_poller.sv
`default_nettype none
// ============================================================================
// Module   : fourway_poller
// Purpose  : Host-side scan sequencer for the 4-way multitap adapter. It
//            drives the port2 player select and the port1 TH line the same
//            way the console BIOS does, reads the ID slot and then all four
//            pads, and publishes decoded active-high button words
//            atomically once per poll.
// Ports    : clk_i          system clock
//            reset_i        asynchronous active-high reset
//            start_i        poll request pulse (ignored while busy/cooling)
//            six_en_i       1 = 6-button TH sequence, 0 = 3-button
//            port1_in_o     to adapter port1_in  (bit6 = TH)
//            port1_dir_o    to adapter port1_dir (1 = released)
//            port1_out_i    from adapter port1_out, active-low pad data
//            port2_in_o     to adapter port2_in  (select [6:4], strobe [1:0])
//            port2_dir_o    to adapter port2_dir
//            present_o      ID slot returned 4'hC on last poll
//            pads_o         4x12 button words {Z,Y,X,MODE,START,C,B,A,R,L,D,U}
//            six_o          per-player 6-button detected on last poll
//            valid_o        one-cycle pulse: pads/six/present updated
//            busy_o         poll in progress
// Revision : 1.0 - initial release
// ============================================================================
module fourway_poller #(
  parameter int SETTLE = 8,
  parameter int GAP    = 100000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        six_en_i,
  output logic [6:0]  port1_in_o,
  output logic [6:0]  port1_dir_o,
  input  logic [6:0]  port1_out_i,
  output logic [6:0]  port2_in_o,
  output logic [6:0]  port2_dir_o,
  output logic        present_o,
  output logic [47:0] pads_o,
  output logic [3:0]  six_o,
  output logic        valid_o,
  output logic        busy_o
);

  localparam int CYC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ID     = 3'd1,
    S_PLAYER = 3'd2,
    S_DONE   = 3'd3,
    S_COOL   = 3'd4
  } state_e;

  state_e             state_q;
  logic [CYC_W-1:0]   cyc_q;
  logic [GAP_W-1:0]   cool_q;
  logic [1:0]         player_q;
  logic [3:0]         step_q;
  logic               six_mode_q;
  logic [47:0]        sh_pads_q;
  logic [3:0]         sh_six_q;
  logic               sh_present_q;
  logic [6:0]         p1_in_q, p1_dir_q, p2_in_q, p2_dir_q;
  logic [47:0]        pads_q;
  logic [3:0]         six_q;
  logic               present_q, valid_q, busy_q;

  logic               hold_done;
  logic               id_ok;
  logic [3:0]         last_step;
  logic [1:0]         next_player;
  logic [11:0]        word_d;
  logic               six_bit_d;
  logic               w_unused_p1_bit6;

  // Pad data lives on [5:0]; the ID nibble on [3:0]. Bit 6 carries nothing.
  assign w_unused_p1_bit6 = port1_out_i[6];

  assign hold_done   = (cyc_q == CYC_W'(SETTLE - 1));
  assign id_ok       = (port1_out_i[3:0] == 4'hC);
  assign last_step   = six_mode_q ? 4'd8 : 4'd2;
  assign next_player = player_q + 2'd1;

  // Merge the current sample into the shadow word of the player being scanned.
  // Steps without a decode entry leave the word untouched.
  always_comb begin
    word_d    = sh_pads_q[12*player_q +: 12];
    six_bit_d = sh_six_q[player_q];
    case (step_q)
      4'd0: begin                       // TH high: C,B,R,L,D,U
        word_d[6:5] = ~port1_out_i[5:4];
        word_d[3:0] = ~port1_out_i[3:0];
      end
      4'd1: begin                       // TH low: START,A
        word_d[7] = ~port1_out_i[5];
        word_d[4] = ~port1_out_i[4];
      end
      4'd5: six_bit_d = (port1_out_i[3:0] == 4'h0);
      4'd6: if (sh_six_q[player_q]) begin   // extra buttons only on a 6-btn pad
        word_d[8]  = ~port1_out_i[3];   // MODE
        word_d[9]  = ~port1_out_i[2];   // X
        word_d[10] = ~port1_out_i[1];   // Y
        word_d[11] = ~port1_out_i[0];   // Z
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      cyc_q        <= '0;
      cool_q       <= '0;
      player_q     <= 2'd0;
      step_q       <= 4'd0;
      six_mode_q   <= 1'b0;
      sh_pads_q    <= '0;
      sh_six_q     <= 4'd0;
      sh_present_q <= 1'b0;
      p1_in_q      <= 7'h7F;
      p1_dir_q     <= 7'h7F;
      p2_in_q      <= 7'h7F;
      p2_dir_q     <= 7'h7F;
      pads_q       <= '0;
      six_q        <= 4'd0;
      present_q    <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && (cool_q == '0)) begin
            six_mode_q   <= six_en_i;
            busy_q       <= 1'b1;
            cyc_q        <= '0;
            sh_pads_q    <= '0;
            sh_six_q     <= 4'd0;
            sh_present_q <= 1'b0;
            p2_dir_q     <= 7'h0C;
            p2_in_q      <= {3'd4, 4'b1100};
            p1_dir_q     <= 7'h3F;
            p1_in_q      <= {1'b1, 6'h3F};
            state_q      <= S_ID;
          end
        end

        S_ID: begin
          if (hold_done) begin
            cyc_q        <= '0;
            sh_present_q <= id_ok;
            if (id_ok) begin
              player_q <= 2'd0;
              step_q   <= 4'd0;
              p2_in_q  <= {3'd0, 4'b1100};
              state_q  <= S_PLAYER;
            end else begin
              // No adapter: skip the pads, results stay all-zero.
              p1_in_q  <= 7'h7F;
              p1_dir_q <= 7'h7F;
              p2_in_q  <= 7'h7F;
              p2_dir_q <= 7'h7F;
              state_q  <= S_DONE;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end

        S_PLAYER: begin
          if (hold_done) begin
            cyc_q                      <= '0;
            sh_pads_q[12*player_q +: 12] <= word_d;
            sh_six_q[player_q]         <= six_bit_d;
            if (step_q == last_step) begin
              step_q  <= 4'd0;
              p1_in_q <= {1'b1, 6'h3F};
              if (player_q == 2'd3) begin
                p1_in_q  <= 7'h7F;
                p1_dir_q <= 7'h7F;
                p2_in_q  <= 7'h7F;
                p2_dir_q <= 7'h7F;
                state_q  <= S_DONE;
              end else begin
                player_q <= next_player;
                p2_in_q  <= {1'b0, next_player, 4'b1100};
              end
            end else begin
              step_q  <= step_q + 4'd1;
              // TH alternates H,L,H,...: the next step is high when this one is odd.
              p1_in_q <= {step_q[0], 6'h3F};
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end

        S_DONE: begin
          pads_q    <= sh_pads_q;
          six_q     <= sh_six_q;
          present_q <= sh_present_q;
          valid_q   <= 1'b1;
          busy_q    <= 1'b0;
          cool_q    <= GAP_W'(GAP);
          state_q   <= S_COOL;
        end

        S_COOL: begin
          if (cool_q <= GAP_W'(1)) begin
            cool_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            cool_q <= cool_q - 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign port1_in_o  = p1_in_q;
  assign port1_dir_o = p1_dir_q;
  assign port2_in_o  = p2_in_q;
  assign port2_dir_o = p2_dir_q;
  assign pads_o      = pads_q;
  assign six_o       = six_q;
  assign present_o   = present_q;
  assign valid_o     = valid_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire
